// File: rtl/axi_mctp_wr_master.sv
// rtl/axi_mctp_wr_master.sv - AXI4 write master turning MCTP VDM fragment commands into write bursts
//
// Purpose: accepts a fragment command (start address, AXI len, 128-bit TLP/MCTP
// header) and then streams LEN+1 payload beats onto the W channel. The header
// replaces bits [127:0] of beat 0. Up to MAX_OUTSTANDING bursts may be awaiting
// their B response; BRESP errors are counted (saturating).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/ready/addr/len/hdr fragment command handshake and fields
//   pld_valid/ready/data         payload beat stream
//   aw*                          AXI write address channel
//   w*                           AXI write data channel
//   bid/bresp/bvalid/bready      AXI write response channel
//   outstanding                  bursts issued on AW without a B yet
//   err_cnt                      number of non-OKAY responses (saturating)
//   done                         one-cycle pulse per accepted B response
//   busy                         FSM active or responses still pending
module axi_mctp_wr_master #(
  parameter int DATA_W          = 256,
  parameter int ADDR_W          = 64,
  parameter int ID_W            = 7,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [127:0]        cmd_hdr,
  input  logic                pld_valid,
  output logic                pld_ready,
  input  logic [DATA_W-1:0]   pld_data,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [63:0]         awuser,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic [15:0]         wuser,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [3:0]          outstanding,
  output logic [15:0]         err_cnt,
  output logic                done,
  output logic                busy
);

  localparam logic [2:0] SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       beat;
  logic [127:0]     hdr_q;
  logic [ID_W-1:0]  next_id;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic b_ok;

  // Response IDs are not needed: responses are only counted, never matched.
  logic unused_bid;
  assign unused_bid = ^bid;

  assign cmd_ready = (state == S_IDLE) && (outstanding < MAX_OUT);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  // A response with nothing outstanding is stray; it is dropped entirely.
  assign b_ok      = bvalid && bready && (outstanding != 4'd0);

  assign awid    = next_id;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awuser  = 64'd0;
  assign wstrb   = '1;
  assign wuser   = 16'd0;

  // W is a pass-through of the payload stream while in S_W only, so W can
  // never start ahead of the AW handshake.
  assign wvalid    = (state == S_W) && pld_valid;
  assign pld_ready = (state == S_W) && wready;
  assign wlast     = (state == S_W) && (beat == awlen);
  assign busy      = (state != S_IDLE) || (outstanding != 4'd0);

  generate
    if (DATA_W > 128) begin : g_wide
      assign wdata = (beat == 8'd0) ? {pld_data[DATA_W-1:128], hdr_q} : pld_data;
    end else begin : g_narrow
      assign wdata = (beat == 8'd0) ? hdr_q : pld_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      beat        <= 8'd0;
      hdr_q       <= 128'd0;
      next_id     <= '0;
      awaddr      <= '0;
      awlen       <= 8'd0;
      awsize      <= 3'd0;
      awburst     <= 2'd0;
      awvalid     <= 1'b0;
      bready      <= 1'b0;
      outstanding <= 4'd0;
      err_cnt     <= 16'd0;
      done        <= 1'b0;
    end else begin
      bready <= 1'b1;
      done   <= b_ok;

      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            awaddr  <= cmd_addr;
            awlen   <= cmd_len;
            awsize  <= SIZE;
            awburst <= 2'b01;
            hdr_q   <= cmd_hdr;
            awvalid <= 1'b1;
            state   <= S_AW;
          end
        end
        S_AW: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            next_id <= next_id + 1'b1;
            beat    <= 8'd0;
            state   <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (wlast) begin
              state <= S_IDLE;
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Simultaneous issue and retire cancel out.
      if (aw_hs && !b_ok) begin
        outstanding <= outstanding + 4'd1;
      end else if (!aw_hs && b_ok) begin
        outstanding <= outstanding - 4'd1;
      end

      if (b_ok && (bresp != 2'b00) && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_mctp_wr_master.sv
// tb/tb_axi_mctp_wr_master.sv - directed self-checking bench for axi_mctp_wr_master
module tb_axi_mctp_wr_master;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic [127:0] cmd_hdr;
  logic         pld_valid;
  logic         pld_ready;
  logic [255:0] pld_data;
  logic [6:0]   awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic [63:0]  awuser;
  logic         awvalid;
  logic         awready;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast;
  logic [15:0]  wuser;
  logic         wvalid;
  logic         wready;
  logic [6:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   outstanding;
  logic [15:0]  err_cnt;
  logic         done;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  axi_mctp_wr_master #(
    .DATA_W(256), .ADDR_W(64), .ID_W(7), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_hdr(cmd_hdr),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .outstanding(outstanding), .err_cnt(err_cnt), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] beat_data(input logic [15:0] seed, input logic [15:0] b);
    return {8{seed, b}};
  endfunction

  function automatic logic [127:0] mk_hdr(input logic som, input logic eom,
                                          input logic [1:0] seq, input logic [3:0] tag);
    return {som, eom, seq, tag, 120'h0011223344556677889900AABBCCDD};
  endfunction

  // Entered just after a negedge with awready=wready=1.
  task automatic do_burst(input logic [63:0] addr, input logic [7:0] len,
                          input logic [127:0] hdr, input logic [6:0] exp_id,
                          input logic [3:0] exp_outst, input bit b_at_aw);
    logic [255:0] exp_d;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_hdr   = hdr;
    #1 check("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("awvalid", awvalid, 1'b1);
    check("awid", awid, exp_id);
    check("awaddr", awaddr, addr);
    check("awlen", awlen, len);
    check("awsize", awsize, 3'd5);
    check("awburst", awburst, 2'b01);
    check("wvalid_before_aw", wvalid, 1'b0);
    if (b_at_aw) begin
      bvalid = 1'b1;
      bresp  = 2'b00;
    end
    @(posedge clk);
    #1 check("outstanding_after_aw", outstanding, exp_outst);
    if (b_at_aw) check("done_with_aw", done, 1'b1);
    @(negedge clk);
    bvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      pld_valid = 1'b1;
      pld_data  = beat_data(16'hD000 | 16'(exp_id), 16'(b));
      exp_d     = pld_data;
      if (b == 0) exp_d[127:0] = hdr;
      #1;
      check("wvalid", wvalid, 1'b1);
      check("wlast", wlast, (b == int'(len)));
      check("wdata", wdata, exp_d);
      @(posedge clk);
      @(negedge clk);
    end
    pld_valid = 1'b0;
    #1 check("wvalid_after_burst", wvalid, 1'b0);
  endtask

  // Entered just after a negedge; leaves at the following negedge.
  task automatic send_b(input logic [1:0] resp, input logic [15:0] exp_err);
    bvalid = 1'b1;
    bresp  = resp;
    @(posedge clk);
    #1;
    check("done_on_b", done, 1'b1);
    check("err_cnt", err_cnt, exp_err);
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    pld_valid = 1'b0;
    bvalid    = 1'b0;
    awready   = 1'b1;
    wready    = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int beat;
    int consumed;
    int c;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_hdr   = '0;
    pld_valid = 1'b0;
    pld_data  = '0;
    awready   = 1'b1;
    wready    = 1'b1;
    bid       = '0;
    bresp     = '0;
    bvalid    = 1'b0;

    // Reset state
    #12;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_outstanding", outstanding, 4'd0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_awid", awid, 7'd0);
    check("rst_awaddr", awaddr, 64'd0);
    check("rst_awsize", awsize, 3'd0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("bready_after_rst", bready, 1'b1);
    @(negedge clk);

    // 1: single LEN=3 burst, SOM seq0 tag6
    do_burst(64'h0000_0000_0000_1000, 8'd3, mk_hdr(1'b1, 1'b0, 2'd0, 4'h6), 7'd0, 4'd1, 1'b0);
    check("t1_wstrb", wstrb, 32'hFFFF_FFFF);
    check("t1_awlock", awlock, 1'b0);
    check("t1_awcache", awcache, 4'd0);
    check("t1_awprot", awprot, 3'd0);
    check("t1_awuser", awuser, 64'd0);
    check("t1_wuser", wuser, 16'd0);
    send_b(2'b00, 16'd0);
    @(posedge clk);
    #1;
    check("t1_done_once", done, 1'b0);
    check("t1_outstanding", outstanding, 4'd0);
    check("t1_busy", busy, 1'b0);
    // Stray B with nothing outstanding
    @(negedge clk);
    bvalid = 1'b1;
    bresp  = 2'b10;
    @(posedge clk);
    #1;
    check("stray_b_done", done, 1'b0);
    check("stray_b_outstanding", outstanding, 4'd0);
    check("stray_b_err", err_cnt, 16'd0);
    @(negedge clk);
    bvalid = 1'b0;

    // 2: four fragments with B held low, fifth stalls
    apply_reset();
    do_burst(64'h2000, 8'd1, mk_hdr(1'b1, 1'b0, 2'd0, 4'h3), 7'd0, 4'd1, 1'b0);
    do_burst(64'h2040, 8'd1, mk_hdr(1'b0, 1'b0, 2'd1, 4'h3), 7'd1, 4'd2, 1'b0);
    do_burst(64'h2080, 8'd1, mk_hdr(1'b0, 1'b0, 2'd2, 4'h3), 7'd2, 4'd3, 1'b0);
    do_burst(64'h20C0, 8'd1, mk_hdr(1'b0, 1'b1, 2'd3, 4'h3), 7'd3, 4'd4, 1'b0);
    cmd_valid = 1'b1;
    cmd_addr  = 64'h3000;
    cmd_len   = 8'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_stall_ready", cmd_ready, 1'b0);
      check("t2_stall_awvalid", awvalid, 1'b0);
      check("t2_stall_outstanding", outstanding, 4'd4);
      @(negedge clk);
    end
    bvalid = 1'b1;
    bresp  = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    #1 check("t2_outstanding_after_b", outstanding, 4'd3);
    do_burst(64'h3000, 8'd0, mk_hdr(1'b1, 1'b1, 2'd0, 4'h4), 7'd4, 4'd4, 1'b0);
    send_b(2'b00, 16'd0);
    send_b(2'b00, 16'd0);
    #1 check("t4_pre_outstanding", outstanding, 4'd2);

    // 4: AW handshake coinciding with a B handshake at outstanding=2
    do_burst(64'h4000, 8'd0, mk_hdr(1'b1, 1'b1, 2'd1, 4'h5), 7'd5, 4'd2, 1'b1);
    check("t4_outstanding_end", outstanding, 4'd2);

    // 3: AW stalled 10 cycles, W ready toggling, payload gaps
    apply_reset();
    awready   = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 64'h0000_00AB_2000_0040;
    cmd_len   = 8'd2;
    cmd_hdr   = mk_hdr(1'b0, 1'b0, 2'd2, 4'h1);
    #1 check("t3_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    pld_valid = 1'b1;
    pld_data  = beat_data(16'h3333, 16'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_awvalid_held", awvalid, 1'b1);
      check("t3_awaddr_held", awaddr, 64'h0000_00AB_2000_0040);
      check("t3_awlen_held", awlen, 8'd2);
      check("t3_no_w_before_aw", wvalid, 1'b0);
      check("t3_no_pld_ready", pld_ready, 1'b0);
      @(negedge clk);
    end
    awready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    beat = 0;
    consumed = 0;
    c = 0;
    while (beat <= 2 && c < 40) begin
      logic [255:0] exp_d;
      pld_valid = (c % 3 != 1);
      wready    = (c % 2 == 1);
      pld_data  = beat_data(16'h3333, 16'(beat));
      exp_d     = pld_data;
      if (beat == 0) exp_d[127:0] = mk_hdr(1'b0, 1'b0, 2'd2, 4'h1);
      #1;
      check("t3_wvalid", wvalid, pld_valid);
      if (pld_valid) begin
        check("t3_wdata", wdata, exp_d);
        check("t3_wlast", wlast, (beat == 2));
        if (pld_ready) consumed++;
      end
      @(posedge clk);
      if (pld_valid && wready) beat++;
      @(negedge clk);
      c++;
    end
    check("t3_budget", (c < 40), 1'b1);
    check("t3_consumed", consumed, 3);
    pld_valid = 1'b1;
    wready    = 1'b1;
    #1;
    check("t3_no_extra_beat", pld_ready, 1'b0);
    check("t3_no_extra_wvalid", wvalid, 1'b0);
    pld_valid = 1'b0;
    @(negedge clk);

    // 5: error counting and saturation
    apply_reset();
    do_burst(64'h5000, 8'd0, mk_hdr(1'b1, 1'b1, 2'd0, 4'h2), 7'd0, 4'd1, 1'b0);
    do_burst(64'h5040, 8'd0, mk_hdr(1'b1, 1'b1, 2'd1, 4'h2), 7'd1, 4'd2, 1'b0);
    do_burst(64'h5080, 8'd0, mk_hdr(1'b1, 1'b1, 2'd2, 4'h2), 7'd2, 4'd3, 1'b0);
    send_b(2'b10, 16'd1);
    send_b(2'b10, 16'd2);
    send_b(2'b11, 16'd3);
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    #1 check("t5_preload", err_cnt, 16'hFFFE);
    do_burst(64'h50C0, 8'd0, mk_hdr(1'b1, 1'b1, 2'd3, 4'h2), 7'd3, 4'd1, 1'b0);
    do_burst(64'h5100, 8'd0, mk_hdr(1'b1, 1'b1, 2'd0, 4'h2), 7'd4, 4'd2, 1'b0);
    send_b(2'b10, 16'hFFFF);
    send_b(2'b11, 16'hFFFF);

    // 6: reset during W beat 2 of LEN=3
    apply_reset();
    cmd_valid = 1'b1;
    cmd_addr  = 64'h6000;
    cmd_len   = 8'd3;
    cmd_hdr   = mk_hdr(1'b1, 1'b0, 2'd0, 4'h7);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      pld_valid = 1'b1;
      pld_data  = beat_data(16'h6666, 16'(b));
      @(posedge clk);
      @(negedge clk);
    end
    pld_data = beat_data(16'h6666, 16'd2);
    #1;
    check("t6_wvalid_beat2", wvalid, 1'b1);
    check("t6_wlast_beat2", wlast, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_wvalid", wvalid, 1'b0);
    check("t6_rst_awvalid", awvalid, 1'b0);
    check("t6_rst_outstanding", outstanding, 4'd0);
    check("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n   = 1'b1;
    pld_valid = 1'b0;
    do_burst(64'h7000, 8'd1, mk_hdr(1'b1, 1'b0, 2'd0, 4'h7), 7'd0, 4'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
